pc_fetch_unit: RTL and testbench

//  Program counter and instruction register for the RAT MCU, upstream of the control unit.
//  - Holds the 10-bit PC that addresses program ROM.
//  - Selects the next PC from immediate, stack or interrupt vector.
//  - Latches the 18-bit ROM word into IR and presents decoded IR_FIVE/IR_TWO to the control unit.
//  - Obeys the control unit's PC_LD/PC_INC/PC_MUX_SEL_MCU/MCU_RST strobes.

---
 rtl/pc_fetch_unit_pkg.sv | 38 +++
 rtl/pc_fetch_unit_if.sv | 40 ++++
 rtl/pc_fetch_unit_ras.sv | 84 ++++++++
 rtl/pc_fetch_unit.sv | 100 ++++++++++
 tb/tb_pc_fetch_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the RAT MCU program-counter / instruction-register slice:
// address and instruction widths, the interrupt vector, the PC source select
// encoding and the instruction field positions used by the control unit.
package pc_fetch_unit_pkg;

   localparam int unsigned PC_W      = 10;
   localparam int unsigned IR_W      = 18;
   localparam logic [PC_W-1:0] INT_VEC = 10'h3FF;
   localparam int unsigned RAS_DEPTH = 8;

   // Instruction field positions
   localparam int unsigned IR_FIVE_HI = 17;
   localparam int unsigned IR_FIVE_LO = 13;
   localparam int unsigned IMMED_HI   = 12;
   localparam int unsigned IMMED_LO   = 3;
   localparam int unsigned IR_TWO_HI  = 1;
   localparam int unsigned IR_TWO_LO  = 0;

   typedef enum logic [1:0] {
      IMMED = 2'b00,
      STACK = 2'b01,
      INTR  = 2'b10,
      RSVD  = 2'b11
   } pc_mux_sel_t;

   function automatic logic [4:0] ir_five_of(input logic [IR_W-1:0] ir);
      return ir[IR_FIVE_HI:IR_FIVE_LO];
   endfunction

   function automatic logic [1:0] ir_two_of(input logic [IR_W-1:0] ir);
      return ir[IR_TWO_HI:IR_TWO_LO];
   endfunction

   function automatic logic [PC_W-1:0] immed_of(input logic [IR_W-1:0] ir);
      return ir[IMMED_HI:IMMED_LO];
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control-unit / program-ROM side bundle of the fetch unit.
// master: control unit plus ROM and scratch RAM (drives strobes and data).
// slave : pc_fetch_unit.
interface pc_fetch_unit_if;
   import pc_fetch_unit_pkg::*;

   logic            MCU_RST;
   logic            PC_LD;
   logic            PC_INC;
   logic [1:0]      PC_MUX_SEL_MCU;
   logic            IR_LD;
   logic [PC_W-1:0] STACK_DATA;
   logic [IR_W-1:0] PROG_DATA;
   logic            RAS_PUSH;
   logic            RAS_POP;

   logic [PC_W-1:0] PROG_ADDR;
   logic [IR_W-1:0] IR;
   logic [4:0]      IR_FIVE;
   logic [1:0]      IR_TWO;
   logic [PC_W-1:0] IMMED_ADDR;
   logic            MUX_ERR;
   logic            RAS_OVF;
   logic            RAS_UNF;

   modport master (
      output MCU_RST, PC_LD, PC_INC, PC_MUX_SEL_MCU, IR_LD,
             STACK_DATA, PROG_DATA, RAS_PUSH, RAS_POP,
      input  PROG_ADDR, IR, IR_FIVE, IR_TWO, IMMED_ADDR,
             MUX_ERR, RAS_OVF, RAS_UNF
   );

   modport slave (
      input  MCU_RST, PC_LD, PC_INC, PC_MUX_SEL_MCU, IR_LD,
             STACK_DATA, PROG_DATA, RAS_PUSH, RAS_POP,
      output PROG_ADDR, IR, IR_FIVE, IR_TWO, IMMED_ADDR,
             MUX_ERR, RAS_OVF, RAS_UNF
   );

endinterface

// File: rtl/pc_fetch_unit_ras.sv
// pc_ras: return-address LIFO with occupancy count and sticky over/underflow
// flags. Top-of-stack is read combinationally and reads 0 when empty.
// A simultaneous push and pop replaces the top entry in place.
module pc_ras #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 10
) (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] pc_in,
   output logic [W-1:0] top,
   output logic         ovf,
   output logic         unf
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic [AW-1:0] top_addr;
   logic [AW-1:0] push_addr;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign top   = empty ? '0 : mem[top_addr];

   // Address and write-enable decode for the storage array
   always_comb begin
      top_addr  = AW'(count - 1'b1);
      push_addr = AW'(count);
      mem_we    = 1'b0;
      mem_waddr = push_addr;
      if (!clr) begin
         if (push && !pop && !full) begin
            mem_we    = 1'b1;
            mem_waddr = push_addr;
         end else if (push && pop && !empty) begin
            mem_we    = 1'b1;
            mem_waddr = top_addr;
         end
      end
   end

   // Storage array write port (contents need no reset; count gates validity)
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[mem_waddr] <= pc_in;
      end
   end

   // Occupancy count and sticky error flags
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (full) ovf <= 1'b1;
               else      count <= count + 1'b1;
            end
            2'b01: begin
               if (empty) unf <= 1'b1;
               else       count <= count - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction register for the RAT MCU.
// PROG_ADDR is the PC register itself; IR captures ROM data on IR_LD.
// Optional feature macro: PC_RAS_EN enables the internal return-address
// stack (pc_ras); when undefined, select 01 takes STACK_DATA and the RAS
// strobes are ignored with RAS_OVF/RAS_UNF tied low.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
(
   input  logic            CLK,
   input  logic            RESET_N,
   pc_fetch_unit_if.slave  bus
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [IR_W-1:0] ir_q;
   logic            mux_err_q;
   logic            mux_err_set;
   logic [PC_W-1:0] stack_src;
   logic [PC_W-1:0] immed_addr;
   pc_mux_sel_t     sel;

   assign sel        = pc_mux_sel_t'(bus.PC_MUX_SEL_MCU);
   assign immed_addr = immed_of(ir_q);

`ifdef PC_RAS_EN
   logic [PC_W-1:0] ras_top;
   logic [PC_W-1:0] unused_stack_data;

   assign unused_stack_data = bus.STACK_DATA;

   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) u_pc_ras (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .clr     (bus.MCU_RST),
      .push    (bus.RAS_PUSH),
      .pop     (bus.RAS_POP),
      .pc_in   (pc_q),
      .top     (ras_top),
      .ovf     (bus.RAS_OVF),
      .unf     (bus.RAS_UNF)
   );

   assign stack_src = ras_top;
`else
   logic unused_ras_strobes;

   assign unused_ras_strobes = bus.RAS_PUSH ^ bus.RAS_POP;
   assign stack_src          = bus.STACK_DATA;
   assign bus.RAS_OVF        = 1'b0;
   assign bus.RAS_UNF        = 1'b0;
`endif

   // Next-PC selection: load beats increment beats hold; reserved select holds
   always_comb begin
      pc_d        = pc_q;
      mux_err_set = 1'b0;
      if (bus.PC_LD) begin
         case (sel)
            IMMED: pc_d = immed_addr;
            STACK: pc_d = stack_src;
            INTR:  pc_d = INT_VEC;
            RSVD:  mux_err_set = 1'b1;
            default: ;
         endcase
      end else if (bus.PC_INC) begin
         pc_d = pc_q + 1'b1;
      end
   end

   // PC, IR and sticky select-error register; MCU_RST acts as a synchronous clear
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pc_q      <= '0;
         ir_q      <= '0;
         mux_err_q <= 1'b0;
      end else if (bus.MCU_RST) begin
         pc_q      <= '0;
         ir_q      <= '0;
         mux_err_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         mux_err_q <= mux_err_q | mux_err_set;
         if (bus.IR_LD) begin
            ir_q <= bus.PROG_DATA;
         end
      end
   end

   assign bus.PROG_ADDR  = pc_q;
   assign bus.IR         = ir_q;
   assign bus.IR_FIVE    = ir_five_of(ir_q);
   assign bus.IR_TWO     = ir_two_of(ir_q);
   assign bus.IMMED_ADDR = immed_addr;
   assign bus.MUX_ERR    = mux_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (default build; the RAS
// scenario is compiled in when PC_RAS_EN is defined).
module tb_pc_fetch_unit;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   pc_fetch_unit_if fu ();

   pc_fetch_unit dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (fu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fu.MCU_RST        = 1'b0;
      fu.PC_LD          = 1'b0;
      fu.PC_INC         = 1'b0;
      fu.PC_MUX_SEL_MCU = 2'b00;
      fu.IR_LD          = 1'b0;
      fu.RAS_PUSH       = 1'b0;
      fu.RAS_POP        = 1'b0;
   endtask

   // Put an address into IR[12:3], then load it into PC via select 00
   task automatic load_pc(input logic [9:0] v);
      fu.PROG_DATA = {5'b00000, v, 3'b000};
      fu.IR_LD     = 1'b1;
      tick();
      fu.IR_LD          = 1'b0;
      fu.PC_LD          = 1'b1;
      fu.PC_MUX_SEL_MCU = 2'b00;
      tick();
      idle_inputs();
   endtask

   task automatic soft_reset();
      fu.MCU_RST = 1'b1;
      tick();
      fu.MCU_RST = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (fu.PROG_ADDR !== 10'h000) begin errors++; $display("FAIL reset_pc: got %h expected %h", fu.PROG_ADDR, 10'h000); end
      checks++; if (fu.IR !== 18'h00000) begin errors++; $display("FAIL reset_ir: got %h expected %h", fu.IR, 18'h00000); end
      checks++; if (fu.MUX_ERR !== 1'b0) begin errors++; $display("FAIL reset_mux_err: got %b expected 0", fu.MUX_ERR); end
      checks++; if (fu.RAS_OVF !== 1'b0) begin errors++; $display("FAIL reset_ras_ovf: got %b expected 0", fu.RAS_OVF); end
      checks++; if (fu.RAS_UNF !== 1'b0) begin errors++; $display("FAIL reset_ras_unf: got %b expected 0", fu.RAS_UNF); end
      rst_n = 1'b1;
      tick();

      // Mid-run asynchronous reset with PC=0x155, IR non-zero and MUX_ERR set
      load_pc(10'h155);
      fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b11;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h155) begin errors++; $display("FAIL midrun_pc_pre: got %h expected %h", fu.PROG_ADDR, 10'h155); end
      checks++; if (fu.MUX_ERR !== 1'b1) begin errors++; $display("FAIL midrun_err_pre: got %b expected 1", fu.MUX_ERR); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (fu.PROG_ADDR !== 10'h000) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", fu.PROG_ADDR, 10'h000); end
      checks++; if (fu.IR !== 18'h00000) begin errors++; $display("FAIL async_reset_ir: got %h expected %h", fu.IR, 18'h00000); end
      checks++; if (fu.MUX_ERR !== 1'b0) begin errors++; $display("FAIL async_reset_mux_err: got %b expected 0", fu.MUX_ERR); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_wrap();
      fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b10;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h3FF) begin errors++; $display("FAIL intvec_load: got %h expected %h", fu.PROG_ADDR, 10'h3FF); end
      fu.PC_INC = 1'b1;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h000) begin errors++; $display("FAIL inc_wrap: got %h expected %h", fu.PROG_ADDR, 10'h000); end
      checks++; if (fu.MUX_ERR !== 1'b0) begin errors++; $display("FAIL wrap_no_flag: got %b expected 0", fu.MUX_ERR); end
      fu.PC_INC = 1'b1; fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b10;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h3FF) begin errors++; $display("FAIL load_beats_inc: got %h expected %h", fu.PROG_ADDR, 10'h3FF); end
   endtask

   task automatic test_fetch();
      load_pc(10'h010);
      fu.PROG_DATA = 18'h20005;
      fu.IR_LD = 1'b1; fu.PC_INC = 1'b1;
      tick();
      idle_inputs();
      checks++; if (fu.IR !== 18'h20005) begin errors++; $display("FAIL fetch_ir: got %h expected %h", fu.IR, 18'h20005); end
      checks++; if (fu.IR_FIVE !== 5'b10000) begin errors++; $display("FAIL fetch_ir_five: got %b expected %b", fu.IR_FIVE, 5'b10000); end
      checks++; if (fu.IR_TWO !== 2'b01) begin errors++; $display("FAIL fetch_ir_two: got %b expected %b", fu.IR_TWO, 2'b01); end
      checks++; if (fu.IMMED_ADDR !== 10'h000) begin errors++; $display("FAIL fetch_immed: got %h expected %h", fu.IMMED_ADDR, 10'h000); end
      checks++; if (fu.PROG_ADDR !== 10'h011) begin errors++; $display("FAIL fetch_pc: got %h expected %h", fu.PROG_ADDR, 10'h011); end
      fu.PROG_DATA = 18'h3FFFF;
      tick();
      checks++; if (fu.IR !== 18'h20005) begin errors++; $display("FAIL ir_hold: got %h expected %h", fu.IR, 18'h20005); end
      checks++; if (fu.PROG_ADDR !== 10'h011) begin errors++; $display("FAIL pc_hold: got %h expected %h", fu.PROG_ADDR, 10'h011); end
   endtask

   task automatic test_branch();
      fu.PROG_DATA = {5'b01010, 10'h0A5, 3'b110};
      fu.IR_LD = 1'b1;
      tick();
      idle_inputs();
      checks++; if (fu.IMMED_ADDR !== 10'h0A5) begin errors++; $display("FAIL immed_field: got %h expected %h", fu.IMMED_ADDR, 10'h0A5); end
      checks++; if (fu.IR_TWO !== 2'b10) begin errors++; $display("FAIL immed_ir_two: got %b expected %b", fu.IR_TWO, 2'b10); end
      fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b00;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h0A5) begin errors++; $display("FAIL load_immed: got %h expected %h", fu.PROG_ADDR, 10'h0A5); end
`ifndef PC_RAS_EN
      fu.STACK_DATA = 10'h123;
      fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b01;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h123) begin errors++; $display("FAIL load_stack: got %h expected %h", fu.PROG_ADDR, 10'h123); end
`endif
   endtask

   task automatic test_mux_err();
      load_pc(10'h040);
      fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b11;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h040) begin errors++; $display("FAIL rsvd_hold_pc: got %h expected %h", fu.PROG_ADDR, 10'h040); end
      checks++; if (fu.MUX_ERR !== 1'b1) begin errors++; $display("FAIL rsvd_sets_err: got %b expected 1", fu.MUX_ERR); end
      fu.PC_INC = 1'b1;
      tick();
      tick();
      idle_inputs();
      checks++; if (fu.MUX_ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", fu.MUX_ERR); end
      checks++; if (fu.PROG_ADDR !== 10'h042) begin errors++; $display("FAIL inc_after_err: got %h expected %h", fu.PROG_ADDR, 10'h042); end
      // MCU_RST beats a simultaneous load and IR capture
      fu.MCU_RST = 1'b1; fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b10;
      fu.IR_LD = 1'b1; fu.PROG_DATA = 18'h1ABCD;
      tick();
      idle_inputs();
      checks++; if (fu.MUX_ERR !== 1'b0) begin errors++; $display("FAIL mcu_rst_err: got %b expected 0", fu.MUX_ERR); end
      checks++; if (fu.PROG_ADDR !== 10'h000) begin errors++; $display("FAIL mcu_rst_pc: got %h expected %h", fu.PROG_ADDR, 10'h000); end
      checks++; if (fu.IR !== 18'h00000) begin errors++; $display("FAIL mcu_rst_ir: got %h expected %h", fu.IR, 18'h00000); end
   endtask

`ifndef PC_RAS_EN
   task automatic test_ras_disabled();
      for (int i = 0; i < 10; i++) begin
         fu.RAS_PUSH = 1'b1;
         tick();
      end
      idle_inputs();
      fu.RAS_POP = 1'b1;
      tick();
      tick();
      idle_inputs();
      checks++; if (fu.RAS_OVF !== 1'b0) begin errors++; $display("FAIL ras_off_ovf: got %b expected 0", fu.RAS_OVF); end
      checks++; if (fu.RAS_UNF !== 1'b0) begin errors++; $display("FAIL ras_off_unf: got %b expected 0", fu.RAS_UNF); end
      fu.STACK_DATA = 10'h2C7;
      fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b01; fu.RAS_POP = 1'b1;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h2C7) begin errors++; $display("FAIL ras_off_stack: got %h expected %h", fu.PROG_ADDR, 10'h2C7); end
   endtask
`else
   task automatic test_ras();
      soft_reset();
      load_pc(10'h100);
      // Pushes of 0x100..0x107 fill the stack; the 9th (0x108) overflows
      for (int i = 0; i < 9; i++) begin
         fu.RAS_PUSH = 1'b1; fu.PC_INC = 1'b1;
         tick();
         if (i == 7) begin
            checks++; if (fu.RAS_OVF !== 1'b0) begin errors++; $display("FAIL ras_full_no_ovf: got %b expected 0", fu.RAS_OVF); end
         end
      end
      idle_inputs();
      checks++; if (fu.RAS_OVF !== 1'b1) begin errors++; $display("FAIL ras_ovf: got %b expected 1", fu.RAS_OVF); end
      fu.RAS_POP = 1'b1; fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b01;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h107) begin errors++; $display("FAIL ras_pop_load: got %h expected %h", fu.PROG_ADDR, 10'h107); end
      // Push+pop overwrites top (0x106) with current PC 0x107
      fu.RAS_PUSH = 1'b1; fu.RAS_POP = 1'b1;
      tick();
      idle_inputs();
      fu.RAS_POP = 1'b1; fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b01;
      tick();
      idle_inputs();
      checks++; if (fu.PROG_ADDR !== 10'h107) begin errors++; $display("FAIL ras_replace_top: got %h expected %h", fu.PROG_ADDR, 10'h107); end
      for (int i = 0; i < 6; i++) begin
         fu.RAS_POP = 1'b1;
         tick();
      end
      idle_inputs();
      checks++; if (fu.RAS_UNF !== 1'b0) begin errors++; $display("FAIL ras_empty_no_unf: got %b expected 0", fu.RAS_UNF); end
      fu.RAS_POP = 1'b1; fu.PC_LD = 1'b1; fu.PC_MUX_SEL_MCU = 2'b01;
      tick();
      idle_inputs();
      checks++; if (fu.RAS_UNF !== 1'b1) begin errors++; $display("FAIL ras_unf: got %b expected 1", fu.RAS_UNF); end
      checks++; if (fu.PROG_ADDR !== 10'h000) begin errors++; $display("FAIL ras_empty_top: got %h expected %h", fu.PROG_ADDR, 10'h000); end
      soft_reset();
      checks++; if (fu.RAS_OVF !== 1'b0) begin errors++; $display("FAIL ras_clr_ovf: got %b expected 0", fu.RAS_OVF); end
      checks++; if (fu.RAS_UNF !== 1'b0) begin errors++; $display("FAIL ras_clr_unf: got %b expected 0", fu.RAS_UNF); end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      fu.STACK_DATA = '0;
      fu.PROG_DATA  = '0;
      idle_inputs();
      test_reset();
      test_wrap();
      test_fetch();
      test_branch();
      test_mux_err();
`ifndef PC_RAS_EN
      test_ras_disabled();
`else
      test_ras();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
